// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, response and shared-ALU signals for alu_share_arbiter.
// slave: arbiter side; master: requester/ALU environment side.
interface alu_share_arbiter_if #(
  parameter int unsigned W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [2:0]   req0_gin;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [2:0]   req1_gin;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [W-1:0] rsp0_result;
  logic         rsp0_z;
  logic         rsp0_n;
  logic         rsp0_v;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [W-1:0] rsp1_result;
  logic         rsp1_z;
  logic         rsp1_n;
  logic         rsp1_v;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_gin;
  logic [W-1:0] alu_sum;
  logic         alu_zout;
  logic         alu_nout;
  logic         alu_vout;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_gin,
    input  req1_valid, req1_a, req1_b, req1_gin,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_z, rsp0_n, rsp0_v,
    output rsp1_valid, rsp1_result, rsp1_z, rsp1_n, rsp1_v,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_gin,
    input  alu_sum, alu_zout, alu_nout, alu_vout
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_gin,
    output req1_valid, req1_a, req1_b, req1_gin,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_z, rsp0_n, rsp0_v,
    input  rsp1_valid, rsp1_result, rsp1_z, rsp1_n, rsp1_v,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_gin,
    output alu_sum, alu_zout, alu_nout, alu_vout
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between two requesters (IDLE -> EXEC -> RESP).
// ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention; otherwise round-robin.
module alu_share_arbiter #(
  parameter int unsigned W = 32
) (
  input logic                clk,
  input logic                rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] GIN_ADD   = 3'b010;
  localparam logic [2:0] GIN_SUB   = 3'b110;
  localparam logic [2:0] GIN_UNDEF = 3'b101;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [2:0]   gin_q, gin_d;
  logic         port_q, port_d;
  logic [W-1:0] res_q, res_d;
  logic         z_q, z_d;
  logic         n_q, n_d;
  logic         v_q, v_d;

  logic win;
  logic accept;
  logic rsp_ready_sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    win = bus.req1_valid & ~bus.req0_valid;
  end
`else
  logic ptr_q, ptr_d;

  always_comb begin
    win = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) win = ptr_q;
    ptr_d = accept ? ~win : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gin_d   = gin_q;
    port_d  = port_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;

    accept        = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
    rsp_ready_sel = port_q ? bus.rsp1_ready : bus.rsp0_ready;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = win ? bus.req1_a   : bus.req0_a;
          b_d     = win ? bus.req1_b   : bus.req0_b;
          gin_d   = win ? bus.req1_gin : bus.req0_gin;
          port_d  = win;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // The ALU's vout is only meaningful for add/sub; 101 is not an ALU op at all.
        if (gin_q == GIN_UNDEF) begin
          res_d = '0;
          z_d   = 1'b1;
          n_d   = 1'b0;
          v_d   = 1'b0;
        end else begin
          res_d = bus.alu_sum;
          z_d   = bus.alu_zout;
          n_d   = bus.alu_nout;
          v_d   = ((gin_q == GIN_ADD) || (gin_q == GIN_SUB)) && bus.alu_vout;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_sel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gin_q   <= '0;
      port_q  <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gin_q   <= gin_d;
      port_q  <= port_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    bus.req0_ready  = accept && !win;
    bus.req1_ready  = accept && win;
    bus.rsp0_valid  = (state_q == S_RESP) && !port_q;
    bus.rsp1_valid  = (state_q == S_RESP) && port_q;
    bus.rsp0_result = res_q;
    bus.rsp0_z      = z_q;
    bus.rsp0_n      = n_q;
    bus.rsp0_v      = v_q;
    bus.rsp1_result = res_q;
    bus.rsp1_z      = z_q;
    bus.rsp1_n      = n_q;
    bus.rsp1_v      = v_q;
    bus.alu_a       = a_q;
    bus.alu_b       = b_q;
    bus.alu_gin     = gin_q;
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural alu32 stand-in.
module tb_alu_share_arbiter;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.W(W)) tif();
  alu_share_arbiter #(.W(W)) dut (.clk(clk), .rst(rst), .bus(tif.slave));

  typedef struct packed {
    logic [2:0]   gin;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } op_t;

  typedef struct packed {
    logic         port;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         v;
  } exp_t;

  op_t  op_q0[$];
  op_t  op_q1[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // ALU stand-in: vout is forced high for non add/sub codes to mimic a stale flag,
  // and 101 returns junk the arbiter must replace.
  logic [W-1:0] alu_s;
  logic         alu_v;
  always_comb begin
    alu_s = '0;
    alu_v = 1'b1;
    case (tif.alu_gin)
      3'b010: begin
        alu_s = tif.alu_a + tif.alu_b;
        alu_v = (tif.alu_a[W-1] == tif.alu_b[W-1]) && (alu_s[W-1] != tif.alu_a[W-1]);
      end
      3'b110: begin
        alu_s = tif.alu_a - tif.alu_b;
        alu_v = (tif.alu_a[W-1] != tif.alu_b[W-1]) && (alu_s[W-1] != tif.alu_a[W-1]);
      end
      3'b111:  alu_s = ($signed(tif.alu_a) < $signed(tif.alu_b)) ? 32'd1 : 32'd0;
      3'b000:  alu_s = tif.alu_a & tif.alu_b;
      3'b001:  alu_s = tif.alu_a | tif.alu_b;
      3'b011:  alu_s = tif.alu_b << tif.alu_a[4:0];
      3'b100:  alu_s = tif.alu_a;
      default: alu_s = 32'hDEAD_BEEF;
    endcase
    tif.alu_sum  = alu_s;
    tif.alu_zout = (tif.alu_gin == 3'b101) ? 1'b0 : (alu_s == '0);
    tif.alu_nout = (tif.alu_gin == 3'b101) ? 1'b1 : alu_s[W-1];
    tif.alu_vout = alu_v;
  end

  // Requester drivers: present queue head, pop after an accepting edge.
  initial begin : drv0
    logic acc;
    tif.req0_valid = 1'b0;
    tif.req0_a = '0; tif.req0_b = '0; tif.req0_gin = '0;
    forever begin
      @(negedge clk);
      acc = tif.req0_valid && tif.req0_ready && !rst;
      @(posedge clk); #1;
      if (acc && op_q0.size() > 0) void'(op_q0.pop_front());
      tif.req0_valid = (op_q0.size() > 0);
      if (op_q0.size() > 0) begin
        tif.req0_a = op_q0[0].a; tif.req0_b = op_q0[0].b; tif.req0_gin = op_q0[0].gin;
      end
    end
  end

  initial begin : drv1
    logic acc;
    tif.req1_valid = 1'b0;
    tif.req1_a = '0; tif.req1_b = '0; tif.req1_gin = '0;
    forever begin
      @(negedge clk);
      acc = tif.req1_valid && tif.req1_ready && !rst;
      @(posedge clk); #1;
      if (acc && op_q1.size() > 0) void'(op_q1.pop_front());
      tif.req1_valid = (op_q1.size() > 0);
      if (op_q1.size() > 0) begin
        tif.req1_a = op_q1[0].a; tif.req1_b = op_q1[0].b; tif.req1_gin = op_q1[0].gin;
      end
    end
  end

  task automatic score(input logic port, input logic [W-1:0] res, input logic z,
                       input logic n, input logic v);
    exp_t got;
    exp_t e;
    got = '{port: port, res: res, z: z, n: n, v: v};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_rsp port=%0d res=%h (no response expected)", port, res);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL rsp got port=%0d res=%h z=%b n=%b v=%b, expected port=%0d res=%h z=%b n=%b v=%b",
                 got.port, got.res, got.z, got.n, got.v, e.port, e.res, e.z, e.n, e.v);
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tif.rsp0_valid && tif.rsp1_valid) begin
          checks++; errors++;
          $display("FAIL both_rsp_valid got 1/1, expected at most one");
        end
        if (tif.rsp0_valid && tif.rsp0_ready)
          score(1'b0, tif.rsp0_result, tif.rsp0_z, tif.rsp0_n, tif.rsp0_v);
        if (tif.rsp1_valid && tif.rsp1_ready)
          score(1'b1, tif.rsp1_result, tif.rsp1_z, tif.rsp1_n, tif.rsp1_v);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic port, input logic [2:0] gin, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] res, input logic z,
                      input logic n, input logic v, input logic score_it);
    op_t o;
    o = '{gin: gin, a: a, b: b};
    if (port) op_q1.push_back(o);
    else      op_q0.push_back(o);
    if (score_it) sb.push_back('{port: port, res: res, z: z, n: n, v: v});
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      if (sb.size() == 0 && op_q0.size() == 0 && op_q1.size() == 0) done = 1;
      else tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending, expected 0", name, sb.size());
    end
  endtask

  task automatic wait_rsp(input string name, input bit port, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = port ? tif.rsp1_valid : tif.rsp0_valid;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout got no rsp%0d_valid, expected one", name, port);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : main
    bit seen;
    tif.rsp0_ready = 1'b1;
    tif.rsp1_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_rsp0_valid", W'(tif.rsp0_valid), '0);
    check("rst_rsp1_valid", W'(tif.rsp1_valid), '0);
    check("rst_rsp0_result", tif.rsp0_result, '0);
    check("rst_alu_a", tif.alu_a, '0);
    check("rst_alu_b", tif.alu_b, '0);
    check("rst_alu_gin", W'(tif.alu_gin), '0);
    check("rst_req_ready", W'({tif.req0_ready, tif.req1_ready}), '0);

    // Single add with latency
    push(1'b0, 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = tif.req0_ready;
    end
    check("add_accept", W'(seen), W'(1));
    @(negedge clk);
    check("add_exec_rsp0_valid", W'(tif.rsp0_valid), '0);
    check("add_exec_alu_a", tif.alu_a, 32'd5);
    check("add_exec_alu_gin", W'(tif.alu_gin), W'(3'b010));
    @(negedge clk);
    check("add_resp_rsp0_valid", W'(tif.rsp0_valid), W'(1));
    drain("add", 20);

    // Sub overflow then AND with stale vout
    push(1'b1, 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    push(1'b1, 3'b000, 32'h0F0F_0000, 32'h0F0F_0000, 32'h0F0F_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("sub", 30);

    // Undefined code and slt
    push(1'b0, 3'b101, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(1'b0, 3'b111, 32'hFFFF_FFFD, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("undef_slt", 30);

    // Contention from reset
    do_reset();
    push(1'b0, 3'b001, 32'd1, 32'd2, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 3'b010, 32'd10, 32'd20, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 3'b000, 32'hFFFF_0000, 32'h0000_FFFF, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 3'b001, 32'd8, 32'd8, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 3'b100, 32'h8000_0000, 32'd5, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 3'b110, 32'd4, 32'd4, '0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_ARB_FIXED_PRIO_EN
    sb.push_back('{port: 1'b0, res: 32'd3, z: 1'b0, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b0, res: 32'd30, z: 1'b0, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b0, res: 32'd0, z: 1'b1, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b0, res: 32'd8, z: 1'b0, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b1, res: 32'h8000_0000, z: 1'b0, n: 1'b1, v: 1'b0});
    sb.push_back('{port: 1'b1, res: 32'd0, z: 1'b1, n: 1'b0, v: 1'b0});
`else
    sb.push_back('{port: 1'b0, res: 32'd3, z: 1'b0, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b1, res: 32'h8000_0000, z: 1'b0, n: 1'b1, v: 1'b0});
    sb.push_back('{port: 1'b0, res: 32'd30, z: 1'b0, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b1, res: 32'd0, z: 1'b1, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b0, res: 32'd0, z: 1'b1, n: 1'b0, v: 1'b0});
    sb.push_back('{port: 1'b0, res: 32'd8, z: 1'b0, n: 1'b0, v: 1'b0});
`endif
    drain("contention", 100);

    // Backpressure on port 0 with port 1 waiting
    tick();
    tif.rsp0_ready = 1'b0;
    push(1'b0, 3'b110, 32'd100, 32'd1, 32'd99, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && op_q0.size() > 0; i++) tick();
    push(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_rsp("bp", 1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp0_valid", W'(tif.rsp0_valid), W'(1));
      check("bp_rsp0_data", {tif.rsp0_result[W-4:0], tif.rsp0_z, tif.rsp0_n, tif.rsp0_v},
            {29'd99, 3'b000});
      check("bp_req_ready", W'({tif.req0_ready, tif.req1_ready}), '0);
      @(negedge clk);
    end
    tick();
    tif.rsp0_ready = 1'b1;
    drain("bp", 30);
    @(negedge clk);
    check("bp_after_rsp0_valid", W'(tif.rsp0_valid), '0);

    // Reset while port 1 response is pending
    tick();
    tif.rsp1_ready = 1'b0;
    push(1'b1, 3'b010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_rsp("rstresp", 1'b1, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rstresp_rsp1_valid", W'(tif.rsp1_valid), '0);
    check("rstresp_alu_gin", W'(tif.alu_gin), '0);
    tick();
    tif.rsp1_ready = 1'b1;
    push(1'b0, 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 3'b100, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    drain("rstresp", 40);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
